// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 UART receiver behind a 2-flop input synchronizer.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the parity_err output.
module uart_rx #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       baudrate,
  input  logic       uart_rxd,
  output logic [7:0] dout,
  output logic       done,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frame_err
);

  localparam int DIV_SLOW = (CLK_FREQ + 8 * 9600) / (16 * 9600);
  localparam int DIV_FAST = (CLK_FREQ + 8 * 115200) / (16 * 115200);
  localparam int DIV_W    = $clog2(DIV_SLOW);

  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(DIV_SLOW - 1);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(DIV_FAST - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t           state_q;
  logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic             baud_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [3:0]       tick_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       dout_q;
  logic             done_q, frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic             par_q;
  logic             parity_err_q;
`endif

  logic [DIV_W-1:0] div_last;
  logic             tick;
  logic             bit_end;
  logic [7:0]       shift_d;

  always_comb begin
    div_last = baud_q ? FAST_LAST : SLOW_LAST;
    tick     = (div_cnt_q == div_last);
    bit_end  = tick && (tick_cnt_q == 4'd15);
    shift_d  = {rxd_sync_q, shift_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rxd_prev_q   <= 1'b1;
      baud_q       <= 1'b0;
      div_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rxd_meta_q  <= uart_rxd;
      rxd_sync_q  <= rxd_meta_q;
      rxd_prev_q  <= rxd_sync_q;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          // Falling edge: restart the divider so tick phase follows this frame.
          if (rxd_prev_q && !rxd_sync_q) begin
            state_q    <= S_START;
            baud_q     <= baudrate;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (tick_cnt_q == 4'd7) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              state_q    <= rxd_sync_q ? S_IDLE : S_DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) tick_cnt_q <= tick_cnt_q + 4'd1;
          if (bit_end) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
`else
            if (bit_cnt_q == 3'd7) state_q <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) tick_cnt_q <= tick_cnt_q + 4'd1;
          if (bit_end) begin
            par_q   <= rxd_sync_q;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick) tick_cnt_q <= tick_cnt_q + 4'd1;
          // Leave at mid-stop so a start bit directly after the stop is caught.
          if (bit_end) begin
            if (rxd_sync_q) begin
              state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{shift_q, par_q}) begin
                parity_err_q <= 1'b1;
              end else begin
                dout_q <= shift_q;
                done_q <= 1'b1;
              end
`else
              dout_q <= shift_q;
              done_q <= 1'b1;
`endif
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (rxd_sync_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dout      = dout_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; pulse counts and dout-at-done are logged on negedge.
// Runs at CLK_FREQ = 16 MHz: dividers round(16e6/153600) = 104 and round(16e6/1843200) = 9.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CLK_FREQ = 16000000;
  localparam int DIV_SLOW = 104;
  localparam int DIV_FAST = 9;
  localparam int BIT_SLOW = 16 * DIV_SLOW;
  localparam int BIT_FAST = 16 * DIV_FAST;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_TICKS = 168;
`else
  localparam int STOP_TICKS = 152;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       baudrate = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] dout;
  logic       done;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       bad_par = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int overlap_cnt = 0, long_cnt = 0, last_done_cyc = 0;
  logic [7:0] dout_log [0:15];
  logic done_prev = 1'b0, ferr_prev = 1'b0;

  uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .baudrate  (baudrate),
    .uart_rxd  (uart_rxd),
    .dout      (dout),
    .done      (done),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    done_prev <= done;
    ferr_prev <= frame_err;
    if (done) begin
      dout_log[done_cnt[3:0]] <= dout;
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (parity_err && (done || frame_err)) overlap_cnt <= overlap_cnt + 1;
`endif
    if (done && frame_err) overlap_cnt <= overlap_cnt + 1;
    if ((done && done_prev) || (frame_err && ferr_prev)) long_cnt <= long_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; baudrate switches to baud_after once the start bit is on the line.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_clks,
                            input logic baud_after, input int rst_bit);
    uart_rxd = 1'b0;
    wait_clks(bit_clks);
    baudrate = baud_after;
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      if (i == rst_bit) begin
        wait_clks(bit_clks / 2);
        n_rst = 1'b0;
        wait_clks(8);
        n_rst = 1'b1;
        wait_clks(bit_clks - bit_clks / 2 - 8);
      end else begin
        wait_clks(bit_clks);
      end
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ bad_par;
    wait_clks(bit_clks);
`endif
    uart_rxd = stop;
    wait_clks(bit_clks);
  endtask

  initial begin
    int d0, f0, p0, start_cyc, lat;
    logic [3:0] idx;

    @(posedge clk);
    #1;
    wait_clks(5);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_done", 32'(done), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    n_rst = 1'b1;
    wait_clks(10);

    // 0xA5 at 9600 baud
    d0 = done_cnt; f0 = ferr_cnt;
    baudrate = 1'b0;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, BIT_SLOW, 1'b0, -1);
    wait_clks(BIT_SLOW / 2);
    lat = last_done_cyc - start_cyc;
    check("a5_done_count", 32'(done_cnt - d0), 32'd1);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("a5_latency_window",
          32'((lat >= STOP_TICKS * DIV_SLOW) && (lat <= STOP_TICKS * DIV_SLOW + 4)), 32'd1);

    // 4-tick glitch at 115200, then 0x3C with a mid-frame baudrate change that must be ignored
    baudrate = 1'b1;
    wait_clks(20);
    d0 = done_cnt; f0 = ferr_cnt;
    uart_rxd = 1'b0;
    wait_clks(4 * DIV_FAST);
    uart_rxd = 1'b1;
    wait_clks(2 * BIT_FAST);
    check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    check("glitch_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    send_frame(8'h3C, 1'b1, BIT_FAST, 1'b0, -1);
    wait_clks(BIT_FAST);
    check("x3c_done_count", 32'(done_cnt - d0), 32'd1);
    check("x3c_dout", 32'(dout), 32'h3C);
    baudrate = 1'b1;

    // 0x55 with low stop bit, then line held low for 3 frame times
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, BIT_FAST, 1'b1, -1);
    wait_clks(3 * 10 * BIT_FAST);
    uart_rxd = 1'b1;
    wait_clks(2 * BIT_FAST);
    check("break_frame_err_count", 32'(ferr_cnt - f0), 32'd1);
    check("break_no_done", 32'(done_cnt - d0), 32'd0);
    check("break_dout_held", 32'(dout), 32'h3C);

    // 0x00 then 0xFF back-to-back
    d0 = done_cnt;
    idx = 4'(d0);
    send_frame(8'h00, 1'b1, BIT_FAST, 1'b1, -1);
    send_frame(8'hFF, 1'b1, BIT_FAST, 1'b1, -1);
    wait_clks(BIT_FAST);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check("b2b_first_dout", 32'(dout_log[idx]), 32'h00);
    check("b2b_second_dout", 32'(dout_log[idx + 4'd1]), 32'hFF);
    check("b2b_dout_final", 32'(dout), 32'hFF);

    // Reset pulse during bit 4 of 0xF0, then 0x81
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hF0, 1'b1, BIT_FAST, 1'b1, 4);
    wait_clks(2 * BIT_FAST);
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_mid_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("rst_mid_dout_cleared", 32'(dout), 32'h00);
    send_frame(8'h81, 1'b1, BIT_FAST, 1'b1, -1);
    wait_clks(BIT_FAST);
    check("x81_done_count", 32'(done_cnt - d0), 32'd1);
    check("x81_dout", 32'(dout), 32'h81);

`ifdef UART_RX_PARITY_EN
    d0 = done_cnt; p0 = perr_cnt;
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1, BIT_FAST, 1'b1, -1);
    wait_clks(BIT_FAST);
    check("par_bad_perr_count", 32'(perr_cnt - p0), 32'd1);
    check("par_bad_no_done", 32'(done_cnt - d0), 32'd0);
    check("par_bad_dout_held", 32'(dout), 32'h81);
    bad_par = 1'b0;
    send_frame(8'h07, 1'b1, BIT_FAST, 1'b1, -1);
    wait_clks(BIT_FAST);
    check("par_good_done_count", 32'(done_cnt - d0), 32'd1);
    check("par_good_dout", 32'(dout), 32'h07);
    check("par_good_no_perr", 32'(perr_cnt - p0), 32'd1);
`else
    p0 = perr_cnt;
    check("no_parity_pulses", 32'(perr_cnt - p0), 32'd0);
`endif

    check("pulse_overlap", 32'(overlap_cnt), 32'd0);
    check("pulse_longer_than_1clk", 32'(long_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning the clk frequency in Hz used to derive the baud dividers.
REQ-002 The block SHALL have port clk  input  1  the single system clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port n_rst  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port baudrate  input  1  0 = 9600 baud, 1 = 115200 baud.
REQ-005 The block SHALL have port uart_rxd  input  1  asynchronous serial line, idle high, logic-level polarity (already un-inverted upstream).
REQ-006 The block SHALL have port dout  output  8  last correctly received byte.
REQ-007 The block SHALL have port done  output  1  one-cycle pulse when dout is updated.
REQ-008 The block SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.

Function
REQ-009 uart_rxd SHALL pass through a 2-flop synchronizer before any use; frame timing is measured from the synchronized signal.
REQ-010 The oversample tick SHALL be 16x baud: divider = round(CLK_FREQ/(16*baud)), i.e. 326 clocks for 9600 and 27 clocks for 115200 at 50 MHz.
REQ-011 The divider counter SHALL restart at 0 on start-bit detection, so tick phase is aligned to each frame.
REQ-012 baudrate SHALL be latched on start-bit detection and held for the whole frame; changes mid-frame SHALL have no effect until the next frame.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE (plus PARITY when configured).
REQ-014 IDLE -> START on a synchronized high-to-low transition of the line.
REQ-015 START SHALL sample the line on tick 8 (mid-bit); if the sample is high, the start bit is a glitch: return to IDLE with no output pulse; if low, go to DATA.
REQ-016 DATA SHALL sample 8 bits LSB first, each 16 ticks after the previous sample, into an internal shift register; a 3-bit counter selects DATA -> STOP after bit 7.
REQ-017 STOP SHALL sample 16 ticks after bit 7; if high, dout <= shift register and done = 1 for exactly one clk, then go to IDLE.
REQ-018 If the stop sample is low, frame_err = 1 for exactly one clk, dout SHALL be unchanged, done SHALL stay 0, and the FSM SHALL go to WAIT_IDLE.
REQ-019 WAIT_IDLE -> IDLE only after the synchronized line is seen high; a break condition (line held low) therefore produces a single frame_err.
REQ-020 Returning to IDLE at mid-stop-bit SHALL allow back-to-back frames with zero idle time between them.
REQ-021 done and frame_err SHALL never be asserted in the same cycle.
REQ-022 dout SHALL hold its value until the next successful frame.

Reset
REQ-023 On a clk edge with n_rst = 0: FSM = IDLE, dout = 8'h00, done = 0, frame_err = 0, counters = 0, synchronizer flops = 1 (idle).
REQ-024 Reset asserted mid-frame SHALL abort the frame without a done or frame_err pulse; after release, the receiver SHALL wait for a fresh falling edge.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined, a PARITY state SHALL sit between DATA and STOP to sample an even-parity bit 16 ticks after bit 7, with STOP sampled 16 ticks later.
REQ-026 With UART_RX_PARITY_EN defined, the output parity_err (1 bit) SHALL be added; on a parity mismatch with a good stop bit, parity_err = 1 for one clk, done = 0, and dout is unchanged.
REQ-027 Without UART_RX_PARITY_EN, frames SHALL be 8N1 with no PARITY state and no parity_err port.

Verification
REQ-028 The bench SHALL send 0xA5 at 9600 baud, 8N1 -> dout = 8'hA5 and done high for exactly 1 clk, about 9.5 bit times (~49,500 clks) after the start edge.
REQ-029 The bench SHALL drive the line low for 4 ticks at 115200 baud, then high -> no done and no frame_err; a following 0x3C frame is received correctly.
REQ-030 The bench SHALL send 0x55 with the stop bit forced low, then hold the line low for 3 frames -> exactly one frame_err pulse, dout unchanged, and recovery after the line goes high.
REQ-031 The bench SHALL send 0x00 then 0xFF back-to-back at 115200 baud with no idle -> two done pulses with dout = 8'h00, then 8'hFF.
REQ-032 The bench SHALL assert n_rst during bit 4 of a frame -> no pulses, dout = 8'h00; the next full frame 0x81 is received correctly.
REQ-033 With UART_RX_PARITY_EN defined, the bench SHALL send 0x07 with parity bit 0 (wrong) -> parity_err pulse, no done; with parity bit 1 -> done and dout = 8'h07.
